audio_seq: RTL
==============

# audio_seq

Parametrised, multi-track successor to the single-track music address sequencer. It waits for the audio codec interface to finish initialisation, then steps a sample-memory address through one of NTRACK tracks at a fixed samples-per-note dwell. Stepping is gated by the codec's `data_over` handshake. It supports loop/one-shot playback, pause, stop and restart. It sits between the codec controller (INIT/INIT_FINISH/data_over) and the music sample ROM (Addr).

## Interface
- ADDR_W, 17: sample ROM address width.
- DIV_W, 16: dwell counter width.
- DIV, 91: clock cycles per sample (minimum dwell); legal range 1..2^DIV_W-1.
- NTRACK, 4: number of tracks.
- TRK_W, 2: track-select width, ≥ clog2(NTRACK).
- AUTOPLAY, 1: if 1, playback of track 0 in loop mode starts automatically after init.

Ports (name, direction, width, meaning):
- Clk  in  1  clock.
- Reset  in  1  reset, synchronous, active-high.
- INIT_FINISH  in  1  codec init complete.
- data_over  in  1  codec has consumed the current sample.
- track_base  in  NTRACK*ADDR_W  packed start address per track; track i is at bits [i*ADDR_W +: ADDR_W].
- track_len  in  NTRACK*ADDR_W  packed sample count per track.
- play  in  1  start pulse; starts track_sel from sample 0.
- track_sel  in  TRK_W  track to start on play.
- loop  in  1  mode latched on play: 1 = loop, 0 = one-shot.
- pause  in  1  level; freezes playback while high.
- stop  in  1  pulse; abort to IDLE.
- INIT  out  1  init request to codec.
- Addr  out  ADDR_W  sample ROM address.
- playing  out  1  high in RUN and PAUSE.
- track_done  out  1  one-cycle pulse at end of track.

## Operation
- States: WAIT, IDLE, RUN, PAUSE. Reset → WAIT.
- Reset values: Addr=0, INIT=0, playing=0, track_done=0, dwell counter=0, offset=0, latched track=0, loop=0.
- INIT is registered. It goes to 1 the first cycle after Reset deasserts and stays at 1 in all states.
- WAIT:
  - INIT_FINISH=1 → IDLE, or → RUN on track 0 with loop=1 if AUTOPLAY=1.
  - play, stop and pause are ignored.
- Command priority in IDLE/RUN/PAUSE: stop > play > pause.
- stop → IDLE. Addr holds its value, playing=0, no track_done.
- play with track_sel < NTRACK and track_len[sel] ≠ 0:
  - Latch base, len and loop for sel.
  - offset=0, counter=0, → RUN. Restarts even if already running.
  - Otherwise play is ignored.
- Addr = latched base + offset, modulo 2^ADDR_W. offset is ADDR_W bits.
- RUN:
  - counter increments while counter < DIV-1.
  - At counter = DIV-1:
    - If data_over=1: counter → 0 and the sample advances.
    - If data_over=0: counter holds at DIV-1 (stall) until data_over=1.
  - Advance with offset < len-1: offset+1.
  - Advance with offset = len-1: track_done pulses.
    - loop=1: offset → 0.
    - loop=0: → IDLE; Addr holds the last sample address.
- PAUSE: entered when pause=1 in RUN; exits to RUN when pause=0. counter, offset and Addr are frozen. stop and play remain effective.
- track_base and track_len are sampled only on play (or the AUTOPLAY start); later changes do not affect the current track.

## Timing
- play sampled at cycle t → Addr = base and playing=1 at t+1.
- Each sample is held for at least DIV cycles: DIV cycles when data_over is already high at the tick, longer while stalled.
- Addr update and track_done pulse occur in the same cycle, the cycle after the advancing tick.
- INIT_FINISH at t → state change and first Addr at t+1.
- Reset mid-playback → all outputs take reset values the next cycle; INIT drops to 0 for that cycle and init is re-requested.

## Test plan
- Reset, AUTOPLAY=1, DIV=4, track0 base=0x100, len=3, INIT_FINISH at cycle 5, data_over=1 → Addr 0x100,0x101,0x102,0x100 with 4-cycle dwell; track_done pulses on each wrap to 0x100.
- One-shot (loop=0), track2 base=0x1FFFE, len=3 → Addr 0x1FFFE,0x1FFFF,0x00000, then track_done, playing=0, Addr holds 0x00000.
- data_over held 0 for 10 cycles at the tick → Addr and counter frozen for those cycles; advance the cycle after data_over=1.
- pause high mid-sample for 7 cycles → Addr unchanged, dwell resumes with the same remaining count; stop and play asserted together → stop wins, IDLE.
- play with track_len=0 or track_sel ≥ NTRACK → no state change; play during WAIT → ignored.
- Reset asserted in RUN → Addr=0, INIT=0, playing=0 the next cycle, state WAIT.

Source files
------------

// File: rtl/audio_seq.sv
// Multi-track sample-ROM address sequencer gated by the codec data_over handshake.
// Latency: play/INIT_FINISH at t -> Addr/playing at t+1; each sample dwells >= DIV cycles.
// Backpressure: data_over low at the dwell tick stalls the counter and address until it rises.
module audio_seq #(
  parameter int ADDR_W   = 17,
  parameter int DIV_W    = 16,
  parameter int DIV      = 91,
  parameter int NTRACK   = 4,
  parameter int TRK_W    = 2,
  parameter int AUTOPLAY = 1
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     INIT_FINISH,
  input  logic                     data_over,
  input  logic [NTRACK*ADDR_W-1:0] track_base,
  input  logic [NTRACK*ADDR_W-1:0] track_len,
  input  logic                     play,
  input  logic [TRK_W-1:0]         track_sel,
  input  logic                     loop,
  input  logic                     pause,
  input  logic                     stop,
  output logic                     INIT,
  output logic [ADDR_W-1:0]        Addr,
  output logic                     playing,
  output logic                     track_done
);

  typedef enum logic [1:0] {S_WAIT, S_IDLE, S_RUN, S_PAUSE} state_t;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

  state_t              state_q, state_d;
  logic                init_q;
  logic [DIV_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   off_q, off_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [ADDR_W-1:0]   len_q, len_d;
  logic                loop_q, loop_d;
  logic                done_q, done_d;

  logic [ADDR_W-1:0]   sel_base, sel_len;
  logic                sel_hit, play_ok;

  // Select the requested track's base/length; an out-of-range select never hits.
  always_comb begin
    sel_base = '0;
    sel_len  = '0;
    sel_hit  = 1'b0;
    for (int i = 0; i < NTRACK; i++) begin
      if (track_sel == TRK_W'(i)) begin
        sel_base = track_base[i*ADDR_W +: ADDR_W];
        sel_len  = track_len[i*ADDR_W +: ADDR_W];
        sel_hit  = 1'b1;
      end
    end
    play_ok = play && sel_hit && (sel_len != '0);
  end

  // Next-state logic: stop beats play beats pause; dwell tick advances only on data_over.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    off_d   = off_q;
    base_d  = base_q;
    len_d   = len_q;
    loop_d  = loop_q;
    done_d  = 1'b0;
    case (state_q)
      S_WAIT: begin
        if (INIT_FINISH) begin
          if (AUTOPLAY != 0) begin
            state_d = S_RUN;
            base_d  = track_base[ADDR_W-1:0];
            len_d   = track_len[ADDR_W-1:0];
            loop_d  = 1'b1;
            off_d   = '0;
            cnt_d   = '0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_IDLE, S_RUN, S_PAUSE: begin
        if (stop) begin
          state_d = S_IDLE;
        end else if (play_ok) begin
          state_d = S_RUN;
          base_d  = sel_base;
          len_d   = sel_len;
          loop_d  = loop;
          off_d   = '0;
          cnt_d   = '0;
        end else if (state_q != S_IDLE) begin
          if (pause) begin
            state_d = S_PAUSE;
          end else begin
            // Leaving PAUSE counts this cycle so the pause adds exactly its own length.
            state_d = S_RUN;
            if (cnt_q < DIV_LAST) begin
              cnt_d = cnt_q + DIV_W'(1);
            end else if (data_over) begin
              cnt_d = '0;
              if (off_q != len_q - ADDR_W'(1)) begin
                off_d = off_q + ADDR_W'(1);
              end else begin
                done_d = 1'b1;
                if (loop_q) off_d = '0;
                else        state_d = S_IDLE;
              end
            end
          end
        end
      end
      default: state_d = S_WAIT;
    endcase
  end

  // State and datapath registers; INIT rises the first cycle out of reset and stays high.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_WAIT;
      init_q  <= 1'b0;
      cnt_q   <= '0;
      off_q   <= '0;
      base_q  <= '0;
      len_q   <= '0;
      loop_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      init_q  <= 1'b1;
      cnt_q   <= cnt_d;
      off_q   <= off_d;
      base_q  <= base_d;
      len_q   <= len_d;
      loop_q  <= loop_d;
      done_q  <= done_d;
    end
  end

  assign INIT       = init_q;
  assign Addr       = base_q + off_q;
  assign playing    = (state_q == S_RUN) || (state_q == S_PAUSE);
  assign track_done = done_q;

endmodule
